// File: rtl/vext_elem_if.sv
// ---------------------------------------------------------------------------
// vext_elem_if
// Handshake bundle for the element-extract unit. Three channels:
//   cmd : cmd_valid/cmd_ready, cmd_idx, cmd_sew, cmd_addr   (master -> slave)
//   in  : in_valid/in_ready, in_data, in_last               (master -> slave)
//   out : out_valid/out_ready, out_data, out_hit, out_addr  (slave -> master)
// The master modport is the requester/stream source, the slave modport is
// the extract unit.
// ---------------------------------------------------------------------------
interface vext_elem_if #(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [IDX_WIDTH-1:0]  cmd_idx;
  logic [2:0]            cmd_sew;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_hit;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output cmd_valid, cmd_idx, cmd_sew, cmd_addr,
    output in_valid, in_data, in_last,
    output out_ready,
    input  cmd_ready, in_ready,
    input  out_valid, out_data, out_hit, out_addr
  );

  modport slave (
    input  cmd_valid, cmd_idx, cmd_sew, cmd_addr,
    input  in_valid, in_data, in_last,
    input  out_ready,
    output cmd_ready, in_ready,
    output out_valid, out_data, out_hit, out_addr
  );
endinterface

// File: rtl/vext_elem.sv
// ---------------------------------------------------------------------------
// vext_elem
// Element-extract unit: accepts a command (index, element width, address),
// then scans a stream of packed 64-bit vector beats, tracking the element
// index of lane 0 of each beat, and returns the single element at the
// commanded index as a 64-bit scalar together with a hit flag and the
// command's address.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - vext_elem_if.slave (cmd / in / out handshake channels)
//
// Configuration macro: VEXT_SIGN_EXT_EN
//   defined   : extracted element is sign-extended to 64 bits
//   undefined : extracted element is zero-extended to 64 bits
// ---------------------------------------------------------------------------
module vext_elem #(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  vext_elem_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q,   idx_d;
  logic [IDX_WIDTH-1:0]  base_q,  base_d;
  logic [1:0]            sew_q,   sew_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  hit_q,   hit_d;
  logic                  sat_q,   sat_d;
  logic [DATA_WIDTH-1:0] elem_q,  elem_d;

  // Elements per beat and the unsaturated base of the following beat.
  // The extra top bit of base_sum flags counter overflow.
  logic [3:0]            epb;
  logic [IDX_WIDTH:0]    base_sum;
  logic                  in_range;
  logic [2:0]            lane;
  logic [5:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext_w [4];

  assign epb      = 4'd8 >> sew_q;
  assign base_sum = {1'b0, base_q} + (IDX_WIDTH+1)'(epb);

  // Once the base counter has saturated it no longer names a real element,
  // so capture is disabled from then on.
  assign in_range = !sat_q && (idx_q >= base_q) && ({1'b0, idx_q} < base_sum);

  // base is always a multiple of EPB while not saturated, so the lane
  // offset only needs the low three bits of the difference.
  assign lane    = idx_q[2:0] - base_q[2:0];
  assign shamt   = 6'({3'b000, lane, 3'b000} << sew_q);
  assign shifted = bus.in_data >> shamt;

  // Per-width extension of the lane-aligned element; SEW=64 passes through.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ext
    localparam int W = 8 << gi;
`ifdef VEXT_SIGN_EXT_EN
    assign ext_w[gi] = {{(DATA_WIDTH-W){shifted[W-1]}}, shifted[W-1:0]};
`else
    assign ext_w[gi] = {{(DATA_WIDTH-W){1'b0}}, shifted[W-1:0]};
`endif
  end
  assign ext_w[3] = shifted;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    sew_d   = sew_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    sat_d   = sat_q;
    elem_d  = elem_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          idx_d   = bus.cmd_idx;
          sew_d   = bus.cmd_sew[2] ? 2'd3 : bus.cmd_sew[1:0];
          addr_d  = bus.cmd_addr;
          base_d  = '0;
          hit_d   = 1'b0;
          sat_d   = 1'b0;
          elem_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.in_valid) begin
          if (!hit_q && in_range) begin
            elem_d = ext_w[sew_q];
            hit_d  = 1'b1;
          end
          if (base_sum[IDX_WIDTH]) begin
            base_d = '1;
            sat_d  = 1'b1;
          end else begin
            base_d = base_sum[IDX_WIDTH-1:0];
          end
          if (bus.in_last) state_d = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      sew_q   <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      sat_q   <= 1'b0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      sew_q   <= sew_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      sat_q   <= sat_d;
      elem_q  <= elem_d;
    end
  end

  // Handshakes are masked while reset is held so nothing is exchanged on
  // an edge whose state update reset will discard.
  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.in_ready  = (state_q == SCAN) && !rst;
  assign bus.out_valid = (state_q == RESP) && !rst;
  assign bus.out_data  = elem_q;
  assign bus.out_hit   = hit_q;
  assign bus.out_addr  = addr_q;

endmodule

// File: tb/tb_vext_elem.sv
module tb_vext_elem;

  typedef struct packed {
    logic [63:0] data;
    logic        hit;
    logic [31:0] addr;
  } exp_t;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  exp_t        exp_q[$];
  exp_t        exp4_q[$];
  logic [63:0] beats_a [32];

  vext_elem_if #(.DATA_WIDTH(64), .IDX_WIDTH(16), .ADDR_WIDTH(32)) bus  ();
  vext_elem_if #(.DATA_WIDTH(64), .IDX_WIDTH(4),  .ADDR_WIDTH(32)) bus4 ();

  vext_elem #(.DATA_WIDTH(64), .IDX_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vext_elem #(.DATA_WIDTH(64), .IDX_WIDTH(4), .ADDR_WIDTH(32)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, req);
    end
  endtask

  // Reference: element idx lives in beat idx/EPB at lane idx%EPB; present
  // only if that beat was streamed.
  function automatic exp_t model(input int sew, input int idx, input logic [31:0] addr, input int nb);
    exp_t        e;
    int          s, w, epb, b, lane;
    logic [63:0] v, mask;
    s = (sew > 3) ? 3 : sew;
    w = 8 << s;
    epb = 8 >> s;
    b = idx / epb;
    lane = idx % epb;
    e.addr = addr;
    if (b < nb) begin
      v = beats_a[b] >> (lane * w);
      if (w < 64) begin
        mask = (64'd1 << w) - 64'd1;
        v = v & mask;
`ifdef VEXT_SIGN_EXT_EN
        if (v[w-1]) v = v | ~mask;
`endif
      end
      e.data = v;
      e.hit  = 1'b1;
    end else begin
      e.data = 64'd0;
      e.hit  = 1'b0;
    end
    return e;
  endfunction

  // Bounded wait (sampled on falling edges) for a ready signal.
  // which: 0 bus.cmd_ready, 1 bus.in_ready, 2 bus4.cmd_ready, 3 bus4.in_ready
  task automatic wait_rdy(input int which, input string name);
    logic r;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      case (which)
        0: r = bus.cmd_ready;
        1: r = bus.in_ready;
        2: r = bus4.cmd_ready;
        default: r = bus4.in_ready;
      endcase
      if (r) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: ready still 0 after 50 cycles, required 1", name);
  endtask

  task automatic do_txn(input int sew, input int idx, input logic [31:0] addr,
                        input int nb, input int hold, input bit gaps);
    exp_t e;
    e = model(sew, idx, addr, nb);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_sew   = 3'(sew);
    bus.cmd_idx   = 16'(idx);
    bus.cmd_addr  = addr;
    wait_rdy(0, "cmd_accept");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = beats_a[b];
      bus.in_last  = (b == nb - 1);
      wait_rdy(1, "beat_accept");
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("out_valid_latency", 64'(bus.out_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_out_data", bus.out_data, e.data);
      check("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Scoreboard monitors: compare whenever a result handshake is visible.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got result data=0x%016h, required none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: data=0x%016h hit=%0d addr=0x%08h (exp 0x%016h/%0d/0x%08h)",
                 n_txn, bus.out_data, bus.out_hit, bus.out_addr, e.data, e.hit, e.addr);
        check("out_data", bus.out_data, e.data);
        check("out_hit", 64'(bus.out_hit), 64'(e.hit));
        check("out_addr", 64'(bus.out_addr), 64'(e.addr));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus4.out_valid && bus4.out_ready) begin
      if (exp4_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out4: got result data=0x%016h, required none", bus4.out_data);
      end else begin
        e = exp4_q.pop_front();
        $display("txn idx4: data=0x%016h hit=%0d addr=0x%08h (exp 0x%016h/%0d/0x%08h)",
                 bus4.out_data, bus4.out_hit, bus4.out_addr, e.data, e.hit, e.addr);
        check("out_data4", bus4.out_data, e.data);
        check("out_hit4", 64'(bus4.out_hit), 64'(e.hit));
        check("out_addr4", 64'(bus4.out_addr), 64'(e.addr));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e4;
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_idx = 0; bus.cmd_sew = 0; bus.cmd_addr = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.out_ready = 0;
    bus4.cmd_valid = 0; bus4.cmd_idx = 0; bus4.cmd_sew = 0; bus4.cmd_addr = 0;
    bus4.in_valid = 0; bus4.in_data = 0; bus4.in_last = 0; bus4.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_hit", 64'(bus.out_hit), 64'd0);
    check("rst_out_addr", 64'(bus.out_addr), 64'd0);

    // Byte element 10 of a two-beat vector.
    beats_a[0] = 64'h0706050403020100;
    beats_a[1] = 64'h0F0E0D0C0B0A0908;
    do_txn(0, 10, 32'hA000_0010, 2, 0, 0);

    // Out of range at SEW=64; all three beats must still be drained.
    for (int i = 0; i < 3; i++) beats_a[i] = {$urandom, $urandom};
    do_txn(3, 5, 32'hA000_0020, 3, 0, 0);

    // Upper word with output backpressure.
    beats_a[0] = 64'h89ABCDEF_01234567;
    do_txn(2, 1, 32'hA000_0030, 1, 4, 0);

    // Negative halfword in the top lane.
    beats_a[0] = 64'h8001_0000_0000_0000;
    do_txn(1, 3, 32'hA000_0040, 1, 0, 0);

    // Reset in the middle of a scan discards the command.
    @(posedge clk); #1;
    bus.cmd_valid = 1; bus.cmd_sew = 0; bus.cmd_idx = 16'd20; bus.cmd_addr = 32'hDEAD_0000;
    wait_rdy(0, "abort_cmd_accept");
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    bus.in_valid = 1; bus.in_data = {$urandom, $urandom}; bus.in_last = 0;
    wait_rdy(1, "abort_beat_accept");
    @(posedge clk); #1;
    bus.in_valid = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midscan_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midscan_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("midscan_rst_in_ready", 64'(bus.in_ready), 64'd0);
    beats_a[0] = 64'h1234_5678_9ABC_DE55;
    do_txn(0, 0, 32'hA000_0050, 1, 0, 0);

    // Narrow index counter: beats in IDLE are refused, then the base
    // counter saturates after the hitting beat.
    @(posedge clk); #1;
    bus4.in_valid = 1; bus4.in_data = 64'hFFFF_FFFF_FFFF_FFFF; bus4.in_last = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_in_ready4", 64'(bus4.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus4.in_valid = 0; bus4.in_last = 0;
    for (int i = 0; i < 4; i++) beats_a[i] = {$urandom, $urandom};
    e4 = model(0, 15, 32'hB000_0060, 4);
    exp4_q.push_back(e4);
    bus4.cmd_valid = 1; bus4.cmd_sew = 0; bus4.cmd_idx = 4'd15; bus4.cmd_addr = 32'hB000_0060;
    wait_rdy(2, "cmd_accept4");
    @(posedge clk); #1;
    bus4.cmd_valid = 0;
    for (int b = 0; b < 4; b++) begin
      bus4.in_valid = 1; bus4.in_data = beats_a[b]; bus4.in_last = (b == 3);
      wait_rdy(3, "beat_accept4");
      @(posedge clk); #1;
    end
    bus4.in_valid = 0; bus4.in_last = 0;
    @(negedge clk);
    check("out_valid_latency4", 64'(bus4.out_valid), 64'd1);
    @(posedge clk); #1;
    bus4.out_ready = 1;
    @(posedge clk); #1;
    bus4.out_ready = 0;

    // Randomized traffic, including SEW codes 4-7 and misses.
    for (int n = 0; n < 60; n++) begin
      int sew, s, epb, nb, idx;
      sew = $urandom_range(0, 7);
      s = (sew > 3) ? 3 : sew;
      epb = 8 >> s;
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) beats_a[i] = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) idx = $urandom_range(0, nb * epb - 1);
      else idx = $urandom_range(0, nb * epb + 10);
      do_txn(sew, idx, $urandom, nb, $urandom_range(0, 3), 1'b1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("scoreboard4_empty", 64'(exp4_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
